icache_line_fill: RTL and testbench

- Memory-side responder for the instruction cache. When the cache reports a miss, this block fetches the aligned line from word-wide main memory and returns it as one 128-bit `dataLine` write.
- Sits between the instruction cache (`hit`/`address`/`dataLine`) and the instruction memory port.
- Sequences LINE_WORDS word reads through a valid/ready handshake, assembles the line, then pulses it to the cache.

---
 rtl/icache_line_fill.sv | 127 ++++++++++++
 tb/tb_icache_line_fill.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_fill.sv
// Instruction-cache line fill engine: on a miss, reads LINE_WORDS words from memory and returns one assembled line.
// Optional macro CRITICAL_WORD_FIRST_EN starts the fetch at the faulting word and wraps within the line.
module icache_line_fill #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_req,
  input  logic [ADDR_W-1:0]              miss_addr,
  output logic                           mem_rd,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic                           mem_ready,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic [DATA_W*LINE_WORDS-1:0]   line_data,
  output logic [ADDR_W-1:0]              line_addr,
  output logic                           line_valid,
  output logic                           busy
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-OFF_W-1:0] base_tag;
  logic [IDX_W-1:0]        start_idx;
  logic [IDX_W-1:0]        beat_cnt;
  logic [IDX_W-1:0]        word_idx;
  logic [IDX_W-1:0]        first_idx;
  logic                    accept;
  logic                    beat;
  logic                    last_beat;
  logic                    unused_addr_bits;

`ifdef CRITICAL_WORD_FIRST_EN
  assign first_idx = miss_addr[OFF_W-1:2];
`else
  assign first_idx = '0;
`endif

  // Low byte-offset bits never affect the fill in the default build.
  assign unused_addr_bits = ^miss_addr[OFF_W-1:0];

  // The word index wraps inside the line, so the tag bits are never disturbed.
  assign word_idx  = start_idx + beat_cnt;
  assign last_beat = (beat_cnt == IDX_W'(LINE_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    line_valid = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    beat       = 1'b0;
    case (state)
      IDLE: begin
        if (miss_req) begin
          accept     = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {base_tag, word_idx, 2'b00};
        if (mem_ready) begin
          beat = 1'b1;
          if (last_beat) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        busy       = 1'b1;
        line_valid = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // line_addr follows the first beat so the previous line stays visible until then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_tag  <= '0;
      start_idx <= '0;
      beat_cnt  <= '0;
      line_data <= '0;
      line_addr <= '0;
    end else begin
      if (accept) begin
        base_tag  <= miss_addr[ADDR_W-1:OFF_W];
        start_idx <= first_idx;
        beat_cnt  <= '0;
      end
      if (beat) begin
        beat_cnt  <= beat_cnt + IDX_W'(1);
        line_addr <= {base_tag, {OFF_W{1'b0}}};
        for (int k = 0; k < LINE_WORDS; k++) begin
          if (word_idx == IDX_W'(k)) begin
            line_data[k*DATA_W +: DATA_W] <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_line_fill.sv
// Randomized self-checking bench for icache_line_fill against a line-level reference model.
// Honours CRITICAL_WORD_FIRST_EN when the same macro is defined for the bench.
module tb_icache_line_fill;

  localparam int LW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         mem_rd;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic [127:0] line_data;
  logic [31:0]  line_addr;
  logic         line_valid;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [127:0] prev_line;
  logic [31:0]  prev_addr;

  icache_line_fill dut (
    .clk        (clk),
    .rst        (rst),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .line_data  (line_data),
    .line_addr  (line_addr),
    .line_valid (line_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One miss from request to the idle cycle after the line pulse. waits<0 means random wait states;
  // hold_next keeps a second miss asserted for next_addr; abort_after resets before beat abort_after.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] key, input int waits,
                               input logic [31:0] next_addr, input bit hold_next, input int abort_after);
    logic [31:0]  base;
    logic [31:0]  ea;
    logic [127:0] exp_line;
    int start;
    int edges;
    int total_waits;
    int w;
    int lim;

    base = addr & 32'hFFFF_FFF0;
`ifdef CRITICAL_WORD_FIRST_EN
    start = int'(addr[3:2]);
`else
    start = 0;
`endif
    for (int j = 0; j < LW; j++) begin
      exp_line[j*32 +: 32] = key ^ (base + 32'(4 * j));
    end

    miss_addr = addr;
    miss_req  = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    if (hold_next) begin
      miss_addr = next_addr;
      miss_req  = 1'b1;
    end else begin
      miss_addr = $urandom;
      miss_req  = 1'b0;
    end
    checkOutput("busy_accept", 128'(busy), 128'd1);
    checkOutput("line_addr_hold", 128'(line_addr), 128'(prev_addr));
    checkOutput("line_data_hold", line_data, prev_line);

    total_waits = 0;
    for (int k = 0; k < LW; k++) begin
      ea = base + 32'(4 * ((start + k) % LW));
      w  = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
      for (int i = 0; i < w; i++) begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        checkOutput("wait_rd", 128'(mem_rd), 128'd1);
        checkOutput("wait_addr", 128'(mem_addr), 128'(ea));
        checkOutput("wait_valid", 128'(line_valid), 128'd0);
        @(posedge clk);
        edges++;
        total_waits++;
        @(negedge clk);
      end
      if (abort_after == k) begin
        rst = 1'b1;
        #1;
        checkOutput("abort_rd", 128'(mem_rd), 128'd0);
        checkOutput("abort_addr", 128'(mem_addr), 128'd0);
        checkOutput("abort_valid", 128'(line_valid), 128'd0);
        checkOutput("abort_busy", 128'(busy), 128'd0);
        checkOutput("abort_line", line_data, 128'd0);
        checkOutput("abort_laddr", 128'(line_addr), 128'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_valid2", 128'(line_valid), 128'd0);
        rst       = 1'b0;
        mem_ready = 1'b0;
        miss_req  = 1'b0;
        prev_line = '0;
        prev_addr = '0;
        return;
      end
      checkOutput("beat_rd", 128'(mem_rd), 128'd1);
      checkOutput("beat_addr", 128'(mem_addr), 128'(ea));
      checkOutput("beat_valid", 128'(line_valid), 128'd0);
      mem_ready = 1'b1;
      mem_rdata = key ^ mem_addr;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end

    mem_ready = 1'b0;
    lim = 0;
    while (!line_valid && lim < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      lim++;
    end
    checkOutput("valid_pulse", 128'(line_valid), 128'd1);
    checkOutput("latency", 128'(edges), 128'(LW + 1 + total_waits));
    checkOutput("line_data", line_data, exp_line);
    checkOutput("line_addr", 128'(line_addr), 128'(base));
    checkOutput("done_rd", 128'(mem_rd), 128'd0);
    checkOutput("done_busy", 128'(busy), 128'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("valid_single", 128'(line_valid), 128'd0);
    checkOutput("idle_busy", 128'(busy), 128'd0);
    checkOutput("line_stable", line_data, exp_line);
    checkOutput("laddr_stable", 128'(line_addr), 128'(base));
    prev_line = exp_line;
    prev_addr = base;
  endtask

  // Idle cycles, optionally with stray mem_ready pulses that must not disturb anything.
  task automatic idleCycles(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      mem_ready = noise ? 1'b1 : 1'b0;
      mem_rdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      checkOutput("idle_rd", 128'(mem_rd), 128'd0);
      checkOutput("idle_valid", 128'(line_valid), 128'd0);
      checkOutput("idle_busy2", 128'(busy), 128'd0);
      checkOutput("idle_line", line_data, prev_line);
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst       = 1'b1;
    miss_req  = 1'b0;
    miss_addr = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    prev_line = '0;
    prev_addr = '0;
    #2;
    checkOutput("rst_rd", 128'(mem_rd), 128'd0);
    checkOutput("rst_addr", 128'(mem_addr), 128'd0);
    checkOutput("rst_line", line_data, 128'd0);
    checkOutput("rst_laddr", 128'(line_addr), 128'd0);
    checkOutput("rst_valid", 128'(line_valid), 128'd0);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] zero-wait fill");
    applyStimulus(32'h0000_0124, 32'hA5A5_0000, 0, 32'h0, 1'b0, -1);
    checkOutput("word0_const", 128'(line_data[31:0]), 128'h A5A5_0120);
    checkOutput("word3_const", 128'(line_data[127:96]), 128'h A5A5_012C);

    $display("[TB] two wait states per beat");
    applyStimulus(32'h0000_0124, 32'hA5A5_0000, 2, 32'h0, 1'b0, -1);

    $display("[TB] stray mem_ready in idle");
    idleCycles(3, 1'b1);

    $display("[TB] miss during busy, held into idle");
    applyStimulus(32'h0000_0120, 32'hA5A5_0000, 1, 32'h0000_0400, 1'b1, -1);
    applyStimulus(32'h0000_0400, 32'hA5A5_0000, 0, 32'h0, 1'b0, -1);

    $display("[TB] reset mid-fill");
    applyStimulus(32'h0000_0208, 32'h1234_0000, 1, 32'h0, 1'b0, 2);
    applyStimulus(32'h0000_0200, 32'h1234_0000, 0, 32'h0, 1'b0, -1);

    $display("[TB] address wrap at top of memory");
    applyStimulus(32'hFFFF_FFF8, 32'hA5A5_0000, 0, 32'h0, 1'b0, -1);

    $display("[TB] randomized fills");
    for (int n = 0; n < 25; n++) begin
      applyStimulus($urandom, $urandom, -1, 32'h0, 1'b0, -1);
      idleCycles(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
